// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the
// unified memory macro. The arbiter connects through the slave modport; the
// environment (core side plus memory) uses the master modport.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch requester
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  // Load/store requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  // Memory macro port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          busy;
  logic          owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified instruction/data memory between the fetch (I)
// and load/store (D) requesters. One transaction at a time:
// IDLE -> ISSUE -> WAIT (LATENCY cycles) -> ACK -> IDLE. Every output is a
// register, so acks and read data appear exactly one cycle after the state
// decision that produces them.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LATENCY    = 2,
  parameter int D_PRIORITY = 1
) (
  input logic clk,
  input logic clr,
  mem_port_arbiter_if.slave bus
);

  // The wait counter is 4 bits wide, which bounds the supported read latency.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_grant;
  logic          w_grant_d;
  logic [3:0]    r_cnt;
  logic          r_last_owner;
  logic          r_owner;
  logic          r_busy;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_i_ack;
  logic [DW-1:0] r_i_rdata;
  logic          r_d_ack;
  logic [DW-1:0] r_d_rdata;

  // Next-state decode and arbitration; on a tie D wins under fixed priority,
  // otherwise the requester that did not own the previous transaction wins.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          w_grant      = 1'b1;
          w_next_state = S_ISSUE;
          if (bus.d_req && (!bus.i_req || (D_PRIORITY != 0) || !r_last_owner))
            w_grant_d = 1'b1;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Command latch, memory strobe, latency counter, ack pulses and read data.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt        <= '0;
      r_last_owner <= 1'b0;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_ack      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_busy   <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            // Loading the memory-port registers here makes them valid during
            // ISSUE; they simply hold afterwards, qualified only by mem_en.
            r_owner      <= w_grant_d;
            r_last_owner <= w_grant_d;
            r_mem_en     <= 1'b1;
            if (w_grant_d) begin
              r_mem_we    <= bus.d_we;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= bus.i_addr;
            end
          end
        end
        S_ISSUE: r_cnt <= 4'(LATENCY - 1);
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            // Last wait cycle: memory data is valid now, so capture it straight
            // into the owner's read-data register alongside its ack.
            if (r_owner) begin
              r_d_ack <= 1'b1;
              if (!r_mem_we) r_d_rdata <= bus.mem_rdata;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_ack     = r_i_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Four instances: 0 = LATENCY 2 with D
// priority, 1 = LATENCY 2 round-robin, 2 = LATENCY 1, 3 = LATENCY 15.
// Each instance has a small memory model returning data only in the cycle
// LATENCY cycles after mem_en.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  i_req = '0;
  logic [3:0]  d_req = '0;
  logic [3:0]  d_we  = '0;
  logic [31:0] i_addr  [4];
  logic [31:0] d_addr  [4];
  logic [31:0] d_wdata [4];

  logic [3:0]  i_ack, d_ack, mem_en, mem_we, busy, owner;
  logic [31:0] i_rdata   [4];
  logic [31:0] d_rdata   [4];
  logic [31:0] mem_addr  [4];
  logic [31:0] mem_wdata [4];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L  = (g == 2) ? 1 : (g == 3) ? 15 : 2;
    localparam int DP = (g == 1) ? 0 : 1;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    logic        pv;
    int          pc;
    logic [31:0] pa;

    assign bus.i_req   = i_req[g];
    assign bus.i_addr  = i_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];

    assign i_ack[g]     = bus.i_ack;
    assign d_ack[g]     = bus.d_ack;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign busy[g]      = bus.busy;
    assign owner[g]     = bus.owner;
    assign i_rdata[g]   = bus.i_rdata;
    assign d_rdata[g]   = bus.d_rdata;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;

    always @(posedge clk or negedge clr) begin
      if (!clr) begin
        pv <= 1'b0;
        pc <= 0;
        pa <= '0;
      end else if (bus.mem_en) begin
        pv <= 1'b1;
        pc <= L - 1;
        pa <= bus.mem_addr;
      end else if (pv) begin
        if (pc == 0) pv <= 1'b0;
        else         pc <= pc - 1;
      end
    end

    assign bus.mem_rdata = (pv && pc == 0) ? mem_f(pa) : 32'hBADB_AD00;

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(L), .D_PRIORITY(DP)) u_dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic single_load(input int k, input int lat, input bit early);
    d_addr[k] = 32'h0000_0440;
    d_we[k]   = 1'b0;
    d_req[k]  = 1'b1;
    for (int t = 1; t <= lat + 3; t++) begin
      tick();
      if (early && t == 1) d_req[k] = 1'b0;
      chk1($sformatf("lat%0d_mem_en_t%0d", lat, t), mem_en[k], (t == 1));
      chk1($sformatf("lat%0d_d_ack_t%0d", lat, t), d_ack[k], (t == lat + 2));
      if (t == lat + 2) begin
        chk32($sformatf("lat%0d_d_rdata", lat), d_rdata[k], 32'hA5A5_0440);
        d_req[k] = 1'b0;
      end
    end
    chk1($sformatf("lat%0d_busy_after", lat), busy[k], 1'b0);
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < 4; k++) begin
      i_addr[k]  = '0;
      d_addr[k]  = '0;
      d_wdata[k] = '0;
    end

    // Reset state
    tick();
    tick();
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_mem_en", mem_en[0], 1'b0);
    chk1("rst_i_ack", i_ack[0], 1'b0);
    chk1("rst_d_ack", d_ack[0], 1'b0);
    chk32("rst_i_rdata", i_rdata[0], 32'h0);
    clr = 1'b1;
    tick();

    // Fetch, LATENCY 2
    i_addr[0] = 32'h0000_0100;
    i_req[0]  = 1'b1;
    tick();
    chk1("fetch_mem_en_t1", mem_en[0], 1'b1);
    chk1("fetch_mem_we_t1", mem_we[0], 1'b0);
    chk32("fetch_mem_addr_t1", mem_addr[0], 32'h0000_0100);
    chk1("fetch_busy_t1", busy[0], 1'b1);
    chk1("fetch_owner_t1", owner[0], 1'b0);
    tick();
    chk1("fetch_mem_en_t2", mem_en[0], 1'b0);
    chk1("fetch_i_ack_t2", i_ack[0], 1'b0);
    tick();
    chk1("fetch_i_ack_t3", i_ack[0], 1'b0);
    tick();
    chk1("fetch_i_ack_t4", i_ack[0], 1'b1);
    chk32("fetch_i_rdata_t4", i_rdata[0], 32'h0050_0093);
    i_req[0] = 1'b0;
    tick();
    chk1("fetch_i_ack_t5", i_ack[0], 1'b0);
    chk1("fetch_busy_t5", busy[0], 1'b0);
    chk32("fetch_i_rdata_hold", i_rdata[0], 32'h0050_0093);

    // Reset asserted while a fetch is waiting on memory
    i_addr[0] = 32'h0000_0104;
    i_req[0]  = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    #1;
    chk1("abort_busy", busy[0], 1'b0);
    chk1("abort_mem_en", mem_en[0], 1'b0);
    chk32("abort_i_rdata", i_rdata[0], 32'h0);
    chk32("abort_mem_addr", mem_addr[0], 32'h0);
    i_req[0] = 1'b0;
    tick();
    tick();
    clr  = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      seen = seen | i_ack[0] | busy[0];
    end
    chk1("abort_no_ack_or_busy", seen, 1'b0);

    // Load then store on D; store must leave d_rdata alone
    d_addr[0] = 32'h0000_0300;
    d_we[0]   = 1'b0;
    d_req[0]  = 1'b1;
    for (int t = 1; t <= 4; t++) tick();
    chk1("load_d_ack", d_ack[0], 1'b1);
    chk32("load_d_rdata", d_rdata[0], 32'hA5A5_0300);
    d_req[0] = 1'b0;
    tick();
    d_addr[0]  = 32'h0000_2000;
    d_wdata[0] = 32'hDEAD_BEEF;
    d_we[0]    = 1'b1;
    d_req[0]   = 1'b1;
    tick();
    chk1("store_mem_en", mem_en[0], 1'b1);
    chk1("store_mem_we", mem_we[0], 1'b1);
    chk32("store_mem_addr", mem_addr[0], 32'h0000_2000);
    chk32("store_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk1("store_owner", owner[0], 1'b1);
    d_addr[0]  = 32'h0000_3000;
    d_wdata[0] = 32'h1111_2222;
    tick();
    chk32("store_addr_latched", mem_addr[0], 32'h0000_2000);
    chk32("store_wdata_latched", mem_wdata[0], 32'hDEAD_BEEF);
    tick();
    chk1("store_d_ack_t3", d_ack[0], 1'b0);
    tick();
    chk1("store_d_ack_t4", d_ack[0], 1'b1);
    chk32("store_d_rdata_kept", d_rdata[0], 32'hA5A5_0300);
    d_req[0] = 1'b0;
    d_we[0]  = 1'b0;
    tick();

    // Request withdrawn before grant: no transaction
    i_req[0] = 1'b1;
    #2;
    i_req[0] = 1'b0;
    tick();
    chk1("withdraw_mem_en", mem_en[0], 1'b0);
    chk1("withdraw_busy", busy[0], 1'b0);

    // Round-robin ties: D, I, D, I
    i_addr[1] = 32'h0000_0100;
    d_addr[1] = 32'h0000_0300;
    i_req[1]  = 1'b1;
    d_req[1]  = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk1($sformatf("rr_d_ack_t%0d", t), d_ack[1], (t % 10 == 4));
      chk1($sformatf("rr_i_ack_t%0d", t), i_ack[1], (t % 10 == 9));
      if (t == 4)  chk32("rr_d_rdata", d_rdata[1], 32'hA5A5_0300);
      if (t == 9)  chk32("rr_i_rdata", i_rdata[1], 32'h0050_0093);
      if (t == 6)  chk1("rr_owner_i", owner[1], 1'b0);
    end
    i_req[1] = 1'b0;
    d_req[1] = 1'b0;
    tick();

    // Fixed D priority starves I until D goes quiet
    i_addr[0] = 32'h0000_0100;
    d_addr[0] = 32'h0000_0300;
    i_req[0]  = 1'b1;
    d_req[0]  = 1'b1;
    for (int t = 1; t <= 19; t++) begin
      tick();
      chk1($sformatf("prio_i_ack_t%0d", t), i_ack[0], 1'b0);
      chk1($sformatf("prio_d_ack_t%0d", t), d_ack[0], (t % 5 == 4));
    end
    d_req[0] = 1'b0;
    for (int t = 20; t <= 24; t++) begin
      tick();
      chk1($sformatf("prio_i_ack_t%0d", t), i_ack[0], (t == 24));
    end
    i_req[0] = 1'b0;
    tick();

    // Latency sweep: single loads
    single_load(0, 2, 1'b0);
    single_load(2, 1, 1'b0);
    single_load(3, 15, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
